axi_mem_responder: RTL and testbench

//  Synthesizable AXI4 slave memory model that consumes the traffic of the AXI test master
//  in simulation benches. It sits directly downstream of that master and in place of the

---
 rtl/axi_mem_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an on-chip word array; one transaction at a time, fixed read latency.
// Every output is a flop, so AW/AR readiness reflects the address valids seen one cycle earlier.
module axi_mem_responder #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int ID_W           = 6,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int RD_LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count,
  output logic [15:0]       err_count
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int AW    = MEM_WORDS_LOG2;
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  // state     | meaning
  // S_IDLE    | waiting for AW/AR, round-robin between them
  // S_RD_WAIT | read latency down-counter running
  // S_RD_DATA | presenting read beats
  // S_WR_DATA | accepting write beats
  // S_WR_RESP | presenting write response
  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_DATA, S_WR_DATA, S_WR_RESP} state_t;

  logic [DATA_W-1:0] mem [0:(2**AW)-1];

  state_t            state_q, state_d;
  logic              prio_rd_q, prio_rd_d;
  logic              awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ID_W-1:0]   bid_q, bid_d, rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        len_q, len_d, beat_q, beat_d;
  logic              incr_q, incr_d, err_q, err_d, werr_q, werr_d;
  logic [AW-1:0]     idx_q, idx_d, idx_nxt;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              mem_we, ar_err, aw_err, wlast_bad;
  logic              unused_addr;

  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};
  assign idx_nxt     = incr_q ? idx_q + 1'b1 : idx_q;
  assign ar_err      = s_axi_arburst[1] || (s_axi_arsize != 3'(OFFS));
  assign aw_err      = s_axi_awburst[1] || (s_axi_awsize != 3'(OFFS));
  assign wlast_bad   = s_axi_wlast != (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    prio_rd_d   = prio_rd_q;
    awready_d   = 1'b0;
    arready_d   = 1'b0;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    bid_d       = bid_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    incr_d      = incr_q;
    err_d       = err_q;
    werr_d      = werr_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    err_count_d = err_count_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          state_d   = S_RD_WAIT;
          prio_rd_d = ~prio_rd_q;
          rid_d     = s_axi_arid;
          len_d     = s_axi_arlen;
          err_d     = ar_err;
          incr_d    = (s_axi_arburst != 2'b00) || ar_err;
          idx_d     = s_axi_araddr[OFFS +: AW];
          beat_d    = 8'd0;
          lat_d     = LAT_W'(RD_LATENCY);
        end else if (s_axi_awvalid && awready_q) begin
          state_d   = S_WR_DATA;
          prio_rd_d = ~prio_rd_q;
          bid_d     = s_axi_awid;
          len_d     = s_axi_awlen;
          err_d     = aw_err;
          incr_d    = (s_axi_awburst != 2'b00) || aw_err;
          idx_d     = s_axi_awaddr[OFFS +: AW];
          beat_d    = 8'd0;
          werr_d    = 1'b0;
          wready_d  = 1'b1;
        end else begin
          // Readies are mutually exclusive so a contended cycle never double-accepts.
          awready_d = s_axi_awvalid && !(s_axi_arvalid && prio_rd_q);
          arready_d = s_axi_arvalid && !(s_axi_awvalid && !prio_rd_q);
        end
      end
      S_RD_WAIT: begin
        if (lat_q == '0) begin
          state_d  = S_RD_DATA;
          rvalid_d = 1'b1;
          rdata_d  = err_q ? '0 : mem[idx_q];
          rresp_d  = err_q ? 2'b10 : 2'b00;
          rlast_d  = (len_q == 8'd0);
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RD_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            state_d    = S_IDLE;
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            rd_count_d = rd_count_q + 32'd1;
            if (err_q && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end else begin
            beat_d  = beat_q + 8'd1;
            idx_d   = idx_nxt;
            rdata_d = err_q ? '0 : mem[idx_nxt];
            rlast_d = (beat_q + 8'd1) == len_q;
          end
        end
      end
      S_WR_DATA: begin
        if (s_axi_wvalid) begin
          mem_we = !err_q;
          if (wlast_bad) werr_d = 1'b1;
          if (beat_q == len_q) begin
            state_d  = S_WR_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || werr_q || wlast_bad) ? 2'b10 : 2'b00;
          end else begin
            beat_d = beat_q + 8'd1;
            idx_d  = idx_nxt;
          end
        end
      end
      S_WR_RESP: begin
        if (s_axi_bready) begin
          state_d    = S_IDLE;
          bvalid_d   = 1'b0;
          wr_count_d = wr_count_q + 32'd1;
          if (bresp_q == 2'b10 && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      prio_rd_q   <= 1'b1;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      bid_q       <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      incr_q      <= 1'b0;
      err_q       <= 1'b0;
      werr_q      <= 1'b0;
      idx_q       <= '0;
      lat_q       <= '0;
      wr_count_q  <= 32'd0;
      rd_count_q  <= 32'd0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      prio_rd_q   <= prio_rd_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      bid_q       <= bid_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      incr_q      <= incr_d;
      err_q       <= err_d;
      werr_q      <= werr_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed bursts plus random traffic against a word-array model.
module tb_axi_mem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic [31:0] wr_count, rd_count;
  logic [15:0] err_count;

  axi_mem_responder #(.ADDR_W(32), .DATA_W(64), .ID_W(6), .MEM_WORDS_LOG2(10), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: word array, counters and the arbitration pointer.
  logic [63:0] mdl [0:1023];
  bit          prio_rd;
  int unsigned m_wr, m_rd, m_err;

  logic [63:0] wq_d[$];
  logic [7:0]  wq_s[$];
  int          wlast_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int beat, input logic [1:0] burst, input bit err);
    int base;
    base = int'(addr[31:3] % 1024);
    if (err || burst == 2'b01) return (base + beat) % 1024;
    return base;
  endfunction

  task automatic model_reset();
    prio_rd = 1'b1;
    m_wr = 0; m_rd = 0; m_err = 0;
  endtask

  task automatic fill(input int len, input logic [63:0] start, input logic [7:0] strb);
    wq_d.delete(); wq_s.delete();
    for (int i = 0; i <= len; i++) begin
      wq_d.push_back(start + 64'(i));
      wq_s.push_back(strb);
    end
    wlast_bad = -1;
  endtask

  task automatic drive_aw(input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz, input logic [5:0] id);
    awaddr = a; awlen = 8'(len); awburst = bu; awsize = sz; awid = id; awvalid = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz, input logic [5:0] id);
    araddr = a; arlen = 8'(len); arburst = bu; arsize = sz; arid = id; arvalid = 1'b1;
  endtask

  task automatic write_rest(input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz, input logic [5:0] id);
    int n, idx;
    bit err, bad;
    err = bu[1] || (sz != 3'd3);
    bad = 1'b0;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("aw_timeout", 64'(n), 0);
    @(negedge clk);
    awvalid = 1'b0;
    prio_rd = !prio_rd;
    for (int b = 0; b <= len; b++) begin
      wdata = wq_d[b]; wstrb = wq_s[b];
      wlast = (b == len) ^ (b == wlast_bad);
      if (b == wlast_bad) bad = 1'b1;
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("w_timeout", 64'(n), 0);
      @(negedge clk);
      idx = widx(a, b, bu, err);
      if (!err) for (int by = 0; by < 8; by++) if (wq_s[b][by]) mdl[idx][by*8 +: 8] = wq_d[b][by*8 +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("b_timeout", 64'(n), 0);
    chk("bresp", bresp, (err || bad) ? 2'b10 : 2'b00);
    chk("bid", bid, id);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    m_wr++;
    if ((err || bad) && m_err < 65535) m_err++;
    chk("bvalid_after", bvalid, 0);
    chk("wr_count", wr_count, m_wr);
    chk("err_count_w", err_count, m_err);
  endtask

  task automatic read_rest(input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz,
                           input logic [5:0] id, input int stall_mode, input bit chk_lat);
    int n, beat, idx, guard;
    bit err, stalled;
    logic [63:0] hd;
    logic hl;
    err = bu[1] || (sz != 3'd3);
    stalled = 1'b0;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ar_timeout", 64'(n), 0);
    @(negedge clk);
    arvalid = 1'b0;
    prio_rd = !prio_rd;
    n = 0;
    while (!rvalid && n < 200) begin @(negedge clk); n++; end
    if (chk_lat) chk("rd_latency", 64'(n), 64'(LAT + 1));
    beat = 0; guard = 0;
    while (beat <= len && guard < 2000) begin
      guard++;
      if (!rvalid) begin rready = 1'b0; @(negedge clk); continue; end
      if (stall_mode == 1 && beat == 2 && !stalled) begin
        stalled = 1'b1;
        rready = 1'b0;
        hd = rdata; hl = rlast;
        repeat (3) begin
          @(negedge clk);
          chk("hold_rdata", rdata, hd);
          chk("hold_rlast", rlast, hl);
          chk("hold_rvalid", rvalid, 1);
        end
        continue;
      end
      if (stall_mode == 2 && $urandom_range(0, 3) == 0) begin rready = 1'b0; @(negedge clk); continue; end
      idx = widx(a, beat, bu, err);
      chk("rdata", rdata, err ? 64'd0 : mdl[idx]);
      chk("rresp", rresp, err ? 2'b10 : 2'b00);
      chk("rlast", rlast, beat == len);
      chk("rid", rid, id);
      rready = 1'b1;
      beat++;
      @(negedge clk);
    end
    rready = 1'b0;
    chk("rd_beats", 64'(beat), 64'(len + 1));
    m_rd++;
    if (err && m_err < 65535) m_err++;
    chk("rvalid_after", rvalid, 0);
    chk("rd_count", rd_count, m_rd);
    chk("err_count_r", err_count, m_err);
  endtask

  task automatic write_burst(input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz, input logic [5:0] id);
    drive_aw(a, len, bu, sz, id);
    write_rest(a, len, bu, sz, id);
  endtask

  task automatic read_burst(input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz,
                            input logic [5:0] id, input int stall_mode, input bit chk_lat);
    drive_ar(a, len, bu, sz, id);
    read_rest(a, len, bu, sz, id, stall_mode, chk_lat);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, len, base, r;
    logic [1:0] bu;
    logic [2:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mdl[i] = 64'd0;
    awvalid = 0; arvalid = 0; wvalid = 0; wlast = 0; bready = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids", {bid, rid, bresp, rresp}, 0);
    chk("rst_counts", {wr_count, rd_count}, 0);
    chk("rst_err_count", err_count, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Give the words the bench reads a known value, then re-enter reset.
    fill(255, 64'd0, 8'hFF);
    write_burst(32'h0, 255, 2'b01, 3'd3, 6'h01);
    do_reset();

    // Contended AW/AR straight after reset: read wins; this write is also the INCR data set.
    fill(7, 64'd1, 8'hFF);
    drive_ar(32'h200, 1, 2'b01, 3'd3, 6'h11);
    drive_aw(32'h40, 7, 2'b01, 3'd3, 6'h22);
    @(negedge clk);
    chk("pair1_arready", arready, prio_rd);
    chk("pair1_awready", awready, !prio_rd);
    if (prio_rd) begin
      read_rest(32'h200, 1, 2'b01, 3'd3, 6'h11, 0, 0);
      write_rest(32'h40, 7, 2'b01, 3'd3, 6'h22);
    end else begin
      write_rest(32'h40, 7, 2'b01, 3'd3, 6'h22);
      read_rest(32'h200, 1, 2'b01, 3'd3, 6'h11, 0, 0);
    end

    // INCR read-back with latency check and a 3-cycle rready stall.
    read_burst(32'h40, 7, 2'b01, 3'd3, 6'h05, 1, 1);

    // Second contended pair: write now has priority; write is the FIXED burst.
    fill(7, 64'd1, 8'hFF);
    drive_aw(32'h100, 7, 2'b00, 3'd3, 6'h33);
    drive_ar(32'h180, 0, 2'b01, 3'd3, 6'h34);
    @(negedge clk);
    chk("pair2_awready", awready, !prio_rd);
    chk("pair2_arready", arready, prio_rd);
    if (prio_rd) begin
      read_rest(32'h180, 0, 2'b01, 3'd3, 6'h34, 0, 0);
      write_rest(32'h100, 7, 2'b00, 3'd3, 6'h33);
    end else begin
      write_rest(32'h100, 7, 2'b00, 3'd3, 6'h33);
      read_rest(32'h180, 0, 2'b01, 3'd3, 6'h34, 0, 0);
    end
    read_burst(32'h100, 0, 2'b01, 3'd3, 6'h06, 0, 0);
    chk("fixed_last_beat", rdata, 64'd8);

    // High address bits are ignored: 0x8000_2040 aliases word 8.
    read_burst(32'h8000_2040, 0, 2'b01, 3'd3, 6'h07, 0, 0);

    // Partial strobe.
    fill(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    write_burst(32'h180, 0, 2'b01, 3'd3, 6'h08);
    fill(0, 64'd0, 8'h01);
    write_burst(32'h180, 0, 2'b01, 3'd3, 6'h09);
    read_burst(32'h180, 0, 2'b01, 3'd3, 6'h0A, 0, 0);
    chk("partial_strobe", rdata, 64'hFFFF_FFFF_FFFF_FF00);

    // INCR wrapping past the end of the array.
    fill(3, 64'hA000, 8'hFF);
    write_burst(32'h1FF0, 3, 2'b01, 3'd3, 6'h0B);
    read_burst(32'h1FF0, 3, 2'b01, 3'd3, 6'h0C, 0, 0);

    // Early wlast: SLVERR but data still lands.
    fill(3, 64'hB000, 8'hFF);
    wlast_bad = 1;
    write_burst(32'h300, 3, 2'b01, 3'd3, 6'h0D);
    read_burst(32'h300, 3, 2'b01, 3'd3, 6'h0E, 0, 0);

    // WRAP burst write is rejected and leaves memory untouched.
    fill(3, 64'hC000, 8'hFF);
    write_burst(32'h300, 3, 2'b10, 3'd3, 6'h0F);
    read_burst(32'h300, 3, 2'b01, 3'd3, 6'h10, 0, 0);

    // Narrow read size: SLVERR and zero data on every beat.
    read_burst(32'h40, 3, 2'b01, 3'd2, 6'h12, 0, 0);

    for (int t = 0; t < 24; t++) begin
      base = $urandom_range(0, 200);
      a = {19'($urandom), 10'(base), 3'b000};
      len = $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      bu = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      sz = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
      if ($urandom_range(0, 1) == 1) begin
        wq_d.delete(); wq_s.delete();
        for (int i = 0; i <= len; i++) begin
          wq_d.push_back({$urandom, $urandom});
          wq_s.push_back(8'($urandom));
        end
        wlast_bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        write_burst(a, len, bu, sz, 6'($urandom));
      end else begin
        read_burst(a, len, bu, sz, 6'($urandom), 2, 0);
      end
    end

    // Reset while read beats are pending aborts the burst.
    drive_ar(32'h40, 7, 2'b01, 3'd3, 6'h15);
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 200) begin @(negedge clk); n++; end
    chk("abort_rvalid_before", rvalid, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_rd_count", rd_count, 0);
    chk("abort_wr_count", wr_count, 0);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_no_rvalid", rvalid, 0);
    read_burst(32'h40, 7, 2'b01, 3'd3, 6'h16, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
